// File: rtl/gb_mem_pkg.sv
// gb_mem_pkg
// Shared definitions for the Game Boy style memory subsystem: the OAM DMA
// state encoding, the standard OAM transfer length, the address of the DMA
// trigger register and the read latency assumed for the source memory.
package gb_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN
    } dma_state_t;

    localparam int          OAM_LEN        = 160;
    localparam logic [15:0] DMA_REG_ADDR   = 16'hFF46;
    localparam int          SRC_RD_LATENCY = 1;

endpackage

// File: rtl/oam_dma_ctrl.sv
// oam_dma_ctrl
// Sequences an OAM DMA transfer of LEN bytes from a 256-byte source page into
// OAM, and arbitrates the shared source memory port between the CPU and the
// DMA engine. The DMA engine owns the port for as long as it is busy.
//
// Ports:
//   clka      clock
//   rsta      synchronous active-low reset
//   start     one-cycle request to begin (or restart) a transfer
//   src_page  source page; the source address is {src_page[6:0], idx}
//   cpu_req   CPU access request to the source memory
//   cpu_we    CPU write enable
//   cpu_addr  CPU address
//   cpu_din   CPU write data
//   cpu_dout  CPU read data, a straight copy of mem_dout
//   cpu_grant CPU access accepted this cycle
//   mem_we    source memory write enable
//   mem_addr  source memory address
//   mem_din   source memory write data
//   mem_dout  source memory read data, valid one cycle after mem_addr
//   oam_we    OAM write enable
//   oam_addr  OAM byte index
//   oam_din   OAM write data
//   busy      transfer in progress
//   done      one-cycle pulse when a transfer completes
module oam_dma_ctrl
    import gb_mem_pkg::*;
#(
    parameter int LEN    = OAM_LEN,
    parameter int ADDR_W = 15,
    parameter int DATA_W = 8
) (
    input  logic              clka,
    input  logic              rsta,
    input  logic              start,
    input  logic [7:0]        src_page,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_din,
    output logic [DATA_W-1:0] cpu_dout,
    output logic              cpu_grant,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout,
    output logic              oam_we,
    output logic [7:0]        oam_addr,
    output logic [DATA_W-1:0] oam_din,
    output logic              busy,
    output logic              done
);

    localparam logic [7:0] LAST_IDX = 8'(LEN - 1);

    dma_state_t  state;
    logic [7:0]  idx;
    logic [6:0]  base;
    logic        wr_pend;
    logic [7:0]  wr_idx;
    logic        done_r;

    // Only the low seven bits of the page select the source; bit 7 is ignored.
    logic unused_src_bit;
    assign unused_src_bit = src_page[7];

    // Transfer sequencer. A start always wins over the current state, so a
    // start during a transfer reloads the page and drops the byte in flight.
    // The read for index k is issued in one cycle and its OAM write lands in
    // the next, which is why wr_pend/wr_idx trail idx by one stage and DRAIN
    // exists only to retire the final write.
    always_ff @(posedge clka) begin
        if (!rsta) begin
            state   <= IDLE;
            idx     <= '0;
            base    <= '0;
            wr_pend <= 1'b0;
            wr_idx  <= '0;
            done_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (start) begin
                base    <= src_page[6:0];
                idx     <= '0;
                wr_pend <= 1'b0;
                state   <= READ;
            end else begin
                case (state)
                    IDLE: begin
                        wr_pend <= 1'b0;
                    end
                    READ: begin
                        wr_pend <= 1'b1;
                        wr_idx  <= idx;
                        idx     <= idx + 8'd1;
                        if (idx == LAST_IDX) begin
                            state <= DRAIN;
                        end
                    end
                    DRAIN: begin
                        wr_pend <= 1'b0;
                        done_r  <= 1'b1;
                        state   <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    // Port arbitration: the CPU sees the memory directly while idle; once a
    // transfer is running its requests are refused and writes are discarded.
    always_comb begin
        mem_din = cpu_din;
        if (state == IDLE) begin
            mem_addr  = cpu_addr;
            mem_we    = cpu_req & cpu_we;
            cpu_grant = cpu_req;
        end else begin
            mem_addr  = ADDR_W'({base, idx});
            mem_we    = 1'b0;
            cpu_grant = 1'b0;
        end
    end

    assign cpu_dout = mem_dout;
    assign oam_we   = wr_pend;
    assign oam_addr = wr_idx;
    assign oam_din  = mem_dout;
    assign busy     = (state != IDLE);
    assign done     = done_r;

endmodule
